// File: rtl/mmio_gpio_bank.sv
// rtl/mmio_gpio_bank.sv - memory-mapped GPIO bank with set/clr/toggle aliases, edge capture and irq
module mmio_gpio_bank #(
  parameter int          NCH   = 2,
  parameter int          WIDTH = 16,
  parameter logic [31:0] BASE  = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic [1:0]             mem_write,
  input  logic                   rd_en,
  output logic [31:0]            rdata,
  output logic                   rd_valid,
  input  logic [NCH*WIDTH-1:0]   gpio_in,
  output logic [NCH*WIDTH-1:0]   gpio_out,
  output logic                   irq
);

  localparam int NW = NCH * WIDTH;

  logic [NW-1:0]    out_q, out_d, pend_q, pend_d, en_q, en_d;
  logic [NW-1:0]    sync1_q, sync2_q, prev_q, edge_w;
  logic [31:0]      rdata_q, rdata_d;
  logic             rd_valid_q;
  logic [31:0]      off, ch_idx, bmask;
  logic [2:0]       reg_sel;
  logic [3:0]       lanes;
  logic             hit, wr_en;
  logic [WIDTH-1:0] m, v;
  logic             unused_bits;

  // Subtraction wraps addresses below BASE to large values, so one compare bounds both ends.
  assign off     = addr - BASE;
  assign hit     = off < 32'(32 * NCH);
  assign ch_idx  = {5'b0, off[31:5]};
  assign reg_sel = off[4:2];

  always_comb begin
    lanes = 4'b0000;
    case (mem_write)
      2'b01:   lanes[addr[1:0]] = 1'b1;
      2'b10:   if (!addr[0]) lanes = addr[1] ? 4'b1100 : 4'b0011;
      2'b11:   if (addr[1:0] == 2'b00) lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  assign bmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign wr_en = hit && (lanes != 4'b0000);
  assign m     = bmask[WIDTH-1:0];
  assign v     = wdata[WIDTH-1:0] & m;
  assign edge_w = sync2_q & ~prev_q;
  assign unused_bits = ^{wdata, bmask};

  always_comb begin
    out_d   = out_q;
    pend_d  = pend_q | edge_w;
    en_d    = en_q;
    rdata_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_en && ch_idx == 32'(c)) begin
        case (reg_sel)
          3'd1: out_d[c*WIDTH +: WIDTH] = (out_q[c*WIDTH +: WIDTH] & ~m) | v;
          3'd2: out_d[c*WIDTH +: WIDTH] = out_q[c*WIDTH +: WIDTH] | v;
          3'd3: out_d[c*WIDTH +: WIDTH] = out_q[c*WIDTH +: WIDTH] & ~v;
          3'd4: out_d[c*WIDTH +: WIDTH] = out_q[c*WIDTH +: WIDTH] ^ v;
          // A fresh edge re-sets the bit even if it is being cleared this cycle.
          3'd5: pend_d[c*WIDTH +: WIDTH] = (pend_q[c*WIDTH +: WIDTH] & ~v) | edge_w[c*WIDTH +: WIDTH];
          3'd6: en_d[c*WIDTH +: WIDTH] = (en_q[c*WIDTH +: WIDTH] & ~m) | v;
          default: ;
        endcase
      end
      if (rd_en && hit && ch_idx == 32'(c)) begin
        case (reg_sel)
          3'd0: rdata_d[WIDTH-1:0] = sync2_q[c*WIDTH +: WIDTH];
          3'd1: rdata_d[WIDTH-1:0] = out_q[c*WIDTH +: WIDTH];
          3'd5: rdata_d[WIDTH-1:0] = pend_q[c*WIDTH +: WIDTH];
          3'd6: rdata_d[WIDTH-1:0] = en_q[c*WIDTH +: WIDTH];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_en && hit;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign gpio_out = out_q;
  assign irq      = |(pend_q & en_q);

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb/tb_mmio_gpio_bank.sv - directed table-driven bench for mmio_gpio_bank
module tb_mmio_gpio_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  mem_write;
  logic        rd_en, rd_valid, irq;
  logic [31:0] gpio_in, gpio_out;

  int checks = 0;
  int failures = 0;

  mmio_gpio_bank #(.NCH(2), .WIDTH(16), .BASE(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .rd_en(rd_en), .rdata(rdata), .rd_valid(rd_valid),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        ev;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    addr = a; wdata = d; mem_write = sz;
    @(negedge clk);
    mem_write = 2'b00;
  endtask

  task automatic do_read(input logic [31:0] a, input logic ev, input logic [31:0] exp, input string n);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk({n, ".valid"}, {31'b0, rd_valid}, {31'b0, ev});
    chk({n, ".data"}, rdata, exp);
    @(negedge clk);
    chk({n, ".valid_drop"}, {31'b0, rd_valid}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; mem_write = 2'b00; rd_en = 1'b0; gpio_in = '0;

    // {is_read, addr, wdata, size, expect_valid, expected (gpio_out for writes, rdata for reads), name}
    tbl.push_back('{0, 32'h104, 32'h0000_00A5, 2'b11, 1'b0, 32'h0000_00A5, "out_word"});
    tbl.push_back('{1, 32'h104, 32'h0,         2'b00, 1'b1, 32'h0000_00A5, "rd_out"});
    tbl.push_back('{0, 32'h104, 32'h0000_00F0, 2'b11, 1'b0, 32'h0000_00F0, "out_f0"});
    tbl.push_back('{0, 32'h108, 32'h0000_000F, 2'b11, 1'b0, 32'h0000_00FF, "set"});
    tbl.push_back('{0, 32'h10C, 32'h0000_0030, 2'b11, 1'b0, 32'h0000_00CF, "clr"});
    tbl.push_back('{0, 32'h110, 32'h0000_0101, 2'b11, 1'b0, 32'h0000_01CE, "tgl"});
    tbl.push_back('{0, 32'h105, 32'h0000_3C00, 2'b01, 1'b0, 32'h0000_3CCE, "byte_lane1"});
    tbl.push_back('{0, 32'h105, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0000_3CCE, "half_misaligned"});
    tbl.push_back('{0, 32'h106, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0000_3CCE, "word_misaligned"});
    tbl.push_back('{0, 32'h106, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0000_3CCE, "half_upper_lanes"});
    tbl.push_back('{0, 32'h11C, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0000_3CCE, "reserved_wr"});
    tbl.push_back('{1, 32'h11C, 32'h0,         2'b00, 1'b1, 32'h0000_0000, "rd_reserved"});
    tbl.push_back('{1, 32'h118, 32'h0,         2'b00, 1'b1, 32'h0000_0000, "rd_irqen0"});
    tbl.push_back('{0, 32'h104, 32'hFFFF_1234, 2'b10, 1'b0, 32'h0000_1234, "half_low"});
    tbl.push_back('{0, 32'h104, 32'h0000_AAAA, 2'b00, 1'b0, 32'h0000_1234, "size_none"});
    tbl.push_back('{0, 32'h140, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0000_1234, "wr_above"});
    tbl.push_back('{0, 32'h0FC, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0000_1234, "wr_below"});
    tbl.push_back('{0, 32'h124, 32'h0000_BEEF, 2'b11, 1'b0, 32'hBEEF_1234, "ch1_out"});
    tbl.push_back('{0, 32'h124, 32'h0000_0011, 2'b01, 1'b0, 32'hBE11_1234, "ch1_byte0"});
    tbl.push_back('{0, 32'h130, 32'h0000_FFFF, 2'b11, 1'b0, 32'h41EE_1234, "ch1_tgl"});
    tbl.push_back('{1, 32'h124, 32'h0,         2'b00, 1'b1, 32'h0000_41EE, "rd_ch1_out"});
    tbl.push_back('{1, 32'h108, 32'h0,         2'b00, 1'b1, 32'h0000_0000, "rd_set_wo"});
    tbl.push_back('{1, 32'h100, 32'h0,         2'b00, 1'b1, 32'h0000_0000, "rd_in0"});
    tbl.push_back('{1, 32'h140, 32'h0,         2'b00, 1'b0, 32'h0000_0000, "rd_above"});
    tbl.push_back('{1, 32'h0FC, 32'h0,         2'b00, 1'b0, 32'h0000_0000, "rd_below"});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.gpio_out", gpio_out, 32'h0);
    chk("rst.irq", {31'b0, irq}, 32'h0);
    chk("rst.rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst.rdata", rdata, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].is_read) begin
        do_read(tbl[i].a, tbl[i].ev, tbl[i].exp, tbl[i].name);
      end else begin
        do_write(tbl[i].a, tbl[i].d, tbl[i].sz);
        chk(tbl[i].name, gpio_out, tbl[i].exp);
      end
    end

    // ch1 bit 2 rising edge with irq enabled: IN after 2 edges, EDGE_PEND/irq after 3.
    do_write(32'h138, 32'h0000_0004, 2'b11);
    gpio_in[18] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("edge.irq_early", {31'b0, irq}, 32'h0);
    addr = 32'h120; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("edge.in_valid", {31'b0, rd_valid}, 32'h1);
    chk("edge.in_data", rdata, 32'h0000_0004);
    chk("edge.irq_set", {31'b0, irq}, 32'h1);
    do_read(32'h134, 1'b1, 32'h0000_0004, "edge.pend");
    do_write(32'h134, 32'h0000_0004, 2'b11);
    chk("edge.w1c_irq", {31'b0, irq}, 32'h0);

    // W1C landing on the same edge that detects a new rise: set wins.
    gpio_in[18] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[18] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr = 32'h134; wdata = 32'h0000_0004; mem_write = 2'b11;
    @(negedge clk);
    mem_write = 2'b00;
    chk("collide.irq", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("collide.irq_hold", {31'b0, irq}, 32'h1);
    do_read(32'h134, 1'b1, 32'h0000_0004, "collide.pend");

    // ch0 edge with irq disabled: captured but does not raise irq on its own.
    do_write(32'h104, 32'h0000_FFFF, 2'b11);
    do_write(32'h134, 32'h0000_0004, 2'b11);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("ch0edge.irq", {31'b0, irq}, 32'h0);
    do_read(32'h114, 1'b1, 32'h0000_0001, "ch0edge.pend");
    gpio_in[18] = 1'b0;
    repeat (3) @(negedge clk);
    gpio_in[18] = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst.irq", {31'b0, irq}, 32'h1);
    chk("pre_rst.gpio_out", gpio_out, 32'h41EE_FFFF);

    // Reset against a same-cycle word write.
    @(negedge clk);
    reset = 1'b1; gpio_in = '0;
    addr = 32'h104; wdata = 32'h0000_1234; mem_write = 2'b11;
    @(negedge clk);
    reset = 1'b0; mem_write = 2'b00;
    chk("mid_rst.gpio_out", gpio_out, 32'h0);
    chk("mid_rst.irq", {31'b0, irq}, 32'h0);
    do_read(32'h104, 1'b1, 32'h0, "mid_rst.out0");
    do_read(32'h114, 1'b1, 32'h0, "mid_rst.pend0");
    do_read(32'h134, 1'b1, 32'h0, "mid_rst.pend1");
    do_read(32'h138, 1'b1, 32'h0, "mid_rst.en1");
    do_read(32'h120, 1'b1, 32'h0, "mid_rst.in1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
